dmem_request_unit: RTL and testbench

Parametrised data-memory request unit for the pipelined MIPS datapath, between the datapath and the memory controller's dcache/icache request ports. It latches load/store requests when an instruction advances on `ihit`, and holds loads until `dhit`. Stores are posted into a `WBUF_DEPTH`-entry write buffer so they retire without stalling. A watchdog halts fetch if memory never answers.

---
 rtl/dmem_request_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_dmem_request_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_request_unit.sv
`timescale 1ns/1ps
// dmem_request_unit
// Data-memory request unit for the pipelined MIPS datapath. Loads are held
// until dhit. Stores are posted into a small write buffer so they retire
// without stalling. A watchdog halts instruction fetch if memory never answers.
module dmem_request_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic                              ihit,
    input  logic                              dhit,
    input  logic                              memRdRq,
    input  logic                              memWrRq,
    input  logic [ADDR_W-1:0]                 rq_addr,
    input  logic [DATA_W-1:0]                 rq_wdata,
    output logic                              imemREN,
    output logic                              dmemREN,
    output logic                              dmemWEN,
    output logic [ADDR_W-1:0]                 dmemaddr,
    output logic [DATA_W-1:0]                 dmemstore,
    output logic                              stall,
    output logic [$clog2(WBUF_DEPTH+1)-1:0]   wbuf_count,
    output logic                              timeout_err
);

    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               rd_pending_reg, rd_pending_next;
    logic [ADDR_W-1:0]  rd_addr_reg, rd_addr_next;
    logic               timeout_err_reg, timeout_err_next;

    // Write-buffer storage; not reset, contents are qualified by count_reg.
    logic [ADDR_W-1:0]  wbuf_addr [WBUF_DEPTH];
    logic [DATA_W-1:0]  wbuf_data [WBUF_DEPTH];

    logic               accept;
    logic               push;
    logic               pop;
    logic               load_cap;
    logic               wbuf_full;
    logic               busy;
    logic               wd_fire;

    // A request is only taken when the datapath actually advances.
    assign accept    = ihit & ~stall;
    assign push      = accept & memWrRq;
    assign load_cap  = accept & memRdRq;
    assign pop       = (state_reg == WRITE) & dhit;
    assign wbuf_full = (count_reg == CNT_W'(WBUF_DEPTH));
    assign busy      = (state_reg != IDLE);

    // Watchdog: counts unanswered cycles of an outstanding access.
    generate
        if (TIMEOUT > 0) begin : g_wd
            logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;

            // Next watchdog count and the edge at which it reaches TIMEOUT.
            always_comb begin
                wd_cnt_next = '0;
                wd_fire     = 1'b0;
                if (busy && !dhit) begin
                    if (wd_cnt_reg == WD_W'(TIMEOUT - 1)) begin
                        wd_fire = 1'b1;
                    end else begin
                        wd_cnt_next = wd_cnt_reg + 1'b1;
                    end
                end
            end

            // Watchdog counter register.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    wd_cnt_reg <= '0;
                end else begin
                    wd_cnt_reg <= wd_cnt_next;
                end
            end
        end else begin : g_no_wd
            assign wd_fire = 1'b0;
        end
    endgenerate

    // Buffer storage write on a captured store.
    always_ff @(posedge CLK) begin
        if (push) begin
            wbuf_addr[wr_ptr_reg] <= rq_addr;
            wbuf_data[wr_ptr_reg] <= rq_wdata;
        end
    end

    // Next-state logic: FIFO bookkeeping, load latch, memory-side FSM, flush.
    always_comb begin
        state_next       = state_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        count_next       = count_reg;
        rd_pending_next  = rd_pending_reg;
        rd_addr_next     = rd_addr_reg;
        timeout_err_next = timeout_err_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!push && pop) begin
            count_next = count_reg - 1'b1;
        end

        if (load_cap) begin
            rd_pending_next = 1'b1;
            rd_addr_next    = rq_addr;
        end
        if (state_reg == READ && dhit) begin
            rd_pending_next = 1'b0;
        end

        // Stores always drain before a pending load, keeping store->load order.
        case (state_reg)
            IDLE: begin
                if (count_next != '0) begin
                    state_next = WRITE;
                end else if (rd_pending_next) begin
                    state_next = READ;
                end
            end
            WRITE: begin
                if (dhit) begin
                    if (count_next != '0) begin
                        state_next = WRITE;
                    end else if (rd_pending_next) begin
                        state_next = READ;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            READ: begin
                if (dhit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Memory never answered: drop everything and halt fetch.
        if (wd_fire) begin
            timeout_err_next = 1'b1;
            count_next       = '0;
            wr_ptr_next      = '0;
            rd_ptr_next      = '0;
            rd_pending_next  = 1'b0;
            state_next       = IDLE;
        end
    end

    // Control and status registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg       <= IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            rd_pending_reg  <= 1'b0;
            rd_addr_reg     <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            rd_pending_reg  <= rd_pending_next;
            rd_addr_reg     <= rd_addr_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    // Memory-side outputs decoded from registered state only.
    always_comb begin
        dmemaddr  = '0;
        dmemstore = '0;
        case (state_reg)
            WRITE: begin
                dmemaddr  = wbuf_addr[rd_ptr_reg];
                dmemstore = wbuf_data[rd_ptr_reg];
            end
            READ: begin
                dmemaddr = rd_addr_reg;
            end
            default: ;
        endcase
    end

    assign dmemWEN     = (state_reg == WRITE);
    assign dmemREN     = (state_reg == READ);
    assign stall       = rd_pending_reg | wbuf_full | timeout_err_reg;
    assign imemREN     = ~timeout_err_reg;
    assign timeout_err = timeout_err_reg;
    assign wbuf_count  = count_reg;

endmodule

// File: tb/tb_dmem_request_unit.sv
`timescale 1ns/1ps
// Testbench for dmem_request_unit: directed stimulus, scoreboard of expected
// memory accesses checked by an independent monitor.
module tb_dmem_request_unit;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic        dhit;
    logic        memRdRq;
    logic        memWrRq;
    logic [31:0] rq_addr;
    logic [31:0] rq_wdata;
    logic        imemREN;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        stall;
    logic [2:0]  wbuf_count;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t exp_q[$];

    dmem_request_unit #(
        .ADDR_W(32),
        .DATA_W(32),
        .WBUF_DEPTH(4),
        .TIMEOUT(8)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .ihit(ihit),
        .dhit(dhit),
        .memRdRq(memRdRq),
        .memWrRq(memWrRq),
        .rq_addr(rq_addr),
        .rq_wdata(rq_wdata),
        .imemREN(imemREN),
        .dmemREN(dmemREN),
        .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr),
        .dmemstore(dmemstore),
        .stall(stall),
        .wbuf_count(wbuf_count),
        .timeout_err(timeout_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit    = 1'b0;
        dhit    = 1'b0;
        memRdRq = 1'b0;
        memWrRq = 1'b0;
        rq_addr = '0;
        rq_wdata = '0;
    endtask

    task automatic push_exp(input logic wr, input logic [31:0] a, input logic [31:0] d);
        acc_t e;
        e.wr = wr;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every access retired by dhit is popped and compared.
    always @(negedge CLK) begin
        if (nRST && (dmemWEN || dmemREN)) begin
            checks++;
            if (dmemWEN && dmemREN) begin
                errors++;
                $display("FAIL enables_exclusive: got WEN=%0b REN=%0b, expected one", dmemWEN, dmemREN);
            end
            if (dhit) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_access: got wr=%0b addr=%0h, expected none", dmemWEN, dmemaddr);
                end else begin
                    acc_t e;
                    e = exp_q.pop_front();
                    $display("retire %s addr=%08h data=%08h", dmemWEN ? "WR" : "RD", dmemaddr, dmemstore);
                    if (e.wr !== dmemWEN || e.addr !== dmemaddr || (e.wr && e.data !== dmemstore)) begin
                        errors++;
                        $display("FAIL access_order: got wr=%0b addr=%0h data=%0h, expected wr=%0b addr=%0h data=%0h",
                                 dmemWEN, dmemaddr, dmemstore, e.wr, e.addr, e.data);
                    end
                end
            end
        end
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation did not terminate");
    end

    initial begin
        idle_inputs();
        nRST = 1'b0;
        repeat (3) cyc();

        // Reset state, observed while reset is held and after release
        chk("rst_imemREN", 32'(imemREN), 32'd1);
        chk("rst_dmemREN", 32'(dmemREN), 32'd0);
        chk("rst_dmemWEN", 32'(dmemWEN), 32'd0);
        nRST = 1'b1;
        cyc();
        chk("rst_count", 32'(wbuf_count), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_addr", dmemaddr, 32'd0);
        chk("rst_store", dmemstore, 32'd0);

        // Single load, dhit sampled three edges after capture
        ihit = 1'b1; memRdRq = 1'b1; rq_addr = 32'h40;
        push_exp(1'b0, 32'h40, 32'h0);
        cyc();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("load_ren", 32'(dmemREN), 32'd1);
            chk("load_addr", dmemaddr, 32'h40);
            chk("load_stall", 32'(stall), 32'd1);
            if (i == 2) dhit = 1'b1;
            cyc();
        end
        dhit = 1'b0;
        chk("load_done_ren", 32'(dmemREN), 32'd0);
        chk("load_done_stall", 32'(stall), 32'd0);

        // Store burst with memory holding off
        for (int i = 0; i < 4; i++) begin
            ihit = 1'b1; memWrRq = 1'b1;
            rq_addr = 32'h100 + 32'(4 * i);
            rq_wdata = 32'hA + 32'(i);
            push_exp(1'b1, rq_addr, rq_wdata);
            if (i == 0) begin
                cyc();
                chk("store_first_wen", 32'(dmemWEN), 32'd1);
                chk("store_first_stall", 32'(stall), 32'd0);
            end else begin
                cyc();
            end
        end
        idle_inputs();
        chk("burst_count_full", 32'(wbuf_count), 32'd4);
        chk("burst_stall_full", 32'(stall), 32'd1);
        // Drain with dhit every cycle; a store offered while full is ignored
        for (int i = 0; i < 4; i++) begin
            dhit = 1'b1;
            ihit = (i == 0); memWrRq = (i == 0); rq_addr = 32'hBAD;
            chk("drain_wen", 32'(dmemWEN), 32'd1);
            chk("drain_addr", dmemaddr, 32'h100 + 32'(4 * i));
            chk("drain_count", 32'(wbuf_count), 32'(4 - i));
            cyc();
        end
        idle_inputs();
        chk("drain_count_zero", 32'(wbuf_count), 32'd0);
        chk("drain_wen_off", 32'(dmemWEN), 32'd0);
        chk("drain_stall_off", 32'(stall), 32'd0);

        // Ordering: store then load to same address
        ihit = 1'b1; memWrRq = 1'b1; rq_addr = 32'h200; rq_wdata = 32'h55;
        push_exp(1'b1, 32'h200, 32'h55);
        cyc();
        memWrRq = 1'b0; memRdRq = 1'b1; rq_addr = 32'h200;
        push_exp(1'b0, 32'h200, 32'h0);
        chk("ord_wen", 32'(dmemWEN), 32'd1);
        chk("ord_stall_store", 32'(stall), 32'd0);
        cyc();
        idle_inputs();
        chk("ord_ren_held1", 32'(dmemREN), 32'd0);
        chk("ord_stall_load", 32'(stall), 32'd1);
        cyc();
        chk("ord_ren_held2", 32'(dmemREN), 32'd0);
        dhit = 1'b1;
        cyc();
        dhit = 1'b0;
        chk("ord_ren_after", 32'(dmemREN), 32'd1);
        chk("ord_wen_after", 32'(dmemWEN), 32'd0);
        chk("ord_addr", dmemaddr, 32'h200);
        dhit = 1'b1;
        cyc();
        dhit = 1'b0;
        chk("ord_done_ren", 32'(dmemREN), 32'd0);
        chk("ord_done_stall", 32'(stall), 32'd0);

        // Wrap with simultaneous push/pop
        for (int i = 0; i < 12; i++) begin
            ihit = 1'b1; memWrRq = 1'b1;
            rq_addr = 32'h300 + 32'(4 * i);
            rq_wdata = 32'h1000 + 32'(i);
            dhit = (i >= 3);
            push_exp(1'b1, rq_addr, rq_wdata);
            cyc();
            chk("wrap_count", 32'(wbuf_count), (i < 3) ? 32'(i + 1) : 32'd3);
            chk("wrap_stall", 32'(stall), 32'd0);
        end
        idle_inputs();
        dhit = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cyc();
            chk("wrap_drain", 32'(wbuf_count), 32'(2 - j));
        end
        dhit = 1'b0;
        chk("wrap_wen_off", 32'(dmemWEN), 32'd0);
        chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a store: store is lost
        ihit = 1'b1; memWrRq = 1'b1; rq_addr = 32'h600; rq_wdata = 32'h66;
        push_exp(1'b1, 32'h600, 32'h66);
        cyc();
        idle_inputs();
        chk("mid_store_wen", 32'(dmemWEN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("async_rst_wen", 32'(dmemWEN), 32'd0);
        chk("async_rst_count", 32'(wbuf_count), 32'd0);
        chk("async_rst_addr", dmemaddr, 32'd0);
        exp_q.delete();
        cyc();
        nRST = 1'b1;
        cyc();

        // Watchdog: load never answered
        ihit = 1'b1; memRdRq = 1'b1; rq_addr = 32'h500;
        cyc();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            chk("wd_ren_wait", 32'(dmemREN), 32'd1);
            chk("wd_err_wait", 32'(timeout_err), 32'd0);
            cyc();
        end
        chk("wd_err_set", 32'(timeout_err), 32'd1);
        chk("wd_ren_off", 32'(dmemREN), 32'd0);
        chk("wd_imem_off", 32'(imemREN), 32'd0);
        chk("wd_stall", 32'(stall), 32'd1);
        ihit = 1'b1; memWrRq = 1'b1; rq_addr = 32'h700;
        cyc(); cyc();
        idle_inputs();
        chk("wd_sticky", 32'(timeout_err), 32'd1);
        chk("wd_ignore_store", 32'(wbuf_count), 32'd0);
        #2 nRST = 1'b0;
        #1;
        chk("wd_rst_err", 32'(timeout_err), 32'd0);
        chk("wd_rst_imem", 32'(imemREN), 32'd1);
        chk("wd_rst_stall", 32'(stall), 32'd0);
        cyc();
        nRST = 1'b1;
        cyc();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
